// File: rtl/alu_exec_unit_if.sv
`default_nettype none
// ============================================================================
// Module   : alu_exec_unit_if
// Purpose  : Operand/result handshake bundle for the execute-stage ALU.
//            The master side issues operations and consumes results; the
//            slave side (the ALU) accepts operations and produces results.
// Signals  : in_valid/in_ready   - operation handshake
//            alu_ctrl, a, b      - operation code and operands
//            out_valid/out_ready - result handshake
//            result, zero, branch_taken - registered outputs
// Revision : 1.0 - initial release
// ============================================================================
interface alu_exec_unit_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       alu_ctrl;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             branch_taken;

    modport master (
        output in_valid, alu_ctrl, a, b, out_ready,
        input  in_ready, out_valid, result, zero, branch_taken
    );

    modport slave (
        input  in_valid, alu_ctrl, a, b, out_ready,
        output in_ready, out_valid, result, zero, branch_taken
    );
endinterface
`default_nettype wire

// File: rtl/alu_exec_unit.sv
`default_nettype none
// ============================================================================
// Module   : alu_exec_unit
// Purpose  : Execute-stage ALU with valid/ready handshakes. Logic, arithmetic
//            and compare ops complete in one cycle; sll shifts one bit per
//            cycle so its latency is 1 + shamt.
// Ports    : clock   - single clock, posedge
//            reset_n - asynchronous active-low reset
//            bus     - alu_exec_unit_if.slave (operands in, result out)
// Revision : 1.0 - initial release
// ============================================================================
module alu_exec_unit #(
    parameter int WIDTH = 32
) (
    input  logic          clock,
    input  logic          reset_n,
    alu_exec_unit_if.slave bus
);
    localparam int SHW = $clog2(WIDTH);

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_BEQ = 4'b0110;
    localparam logic [3:0] OP_BNE = 4'b0011;
    localparam logic [3:0] OP_BLT = 4'b1000;
    localparam logic [3:0] OP_SLT = 4'b0111;
    localparam logic [3:0] OP_XOR = 4'b1001;
    localparam logic [3:0] OP_SLL = 4'b0100;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] acc_q;
    logic [SHW-1:0]   cnt_q;
    logic [WIDTH-1:0] result_q;
    logic             zero_q;
    logic             branch_q;
    logic             out_valid_q;

    logic             accept_d;
    logic             lt_d;
    logic [WIDTH-1:0] diff_d;
    logic [WIDTH-1:0] op_result_d;
    logic             op_branch_d;
    logic [SHW-1:0]   shamt_d;
    logic             iter_shift_d;
    logic [WIDTH-1:0] acc_shl_d;

    // DONE can accept a new op in the same edge that its result is consumed.
    assign bus.in_ready = (state_q == S_IDLE) ||
                          ((state_q == S_DONE) && bus.out_ready);
    assign accept_d     = bus.in_valid && bus.in_ready;

    assign bus.out_valid    = out_valid_q;
    assign bus.result       = result_q;
    assign bus.zero         = zero_q;
    assign bus.branch_taken = branch_q;

    assign shamt_d      = bus.b[SHW-1:0];
    assign iter_shift_d = (bus.alu_ctrl == OP_SLL) && (shamt_d != '0);
    assign acc_shl_d    = acc_q << 1;
    assign lt_d         = $signed(bus.a) < $signed(bus.b);
    assign diff_d       = bus.a - bus.b;

    // Single-cycle datapath. For sll this yields a, which is the correct
    // result only when shamt is zero; nonzero shifts go through SHIFT.
    always_comb begin
        op_result_d = bus.a + bus.b;
        op_branch_d = 1'b0;
        case (bus.alu_ctrl)
            OP_AND: op_result_d = bus.a & bus.b;
            OP_OR:  op_result_d = bus.a | bus.b;
            OP_ADD: op_result_d = bus.a + bus.b;
            OP_BEQ: begin
                op_result_d = diff_d;
                op_branch_d = (bus.a == bus.b);
            end
            OP_BNE: begin
                op_result_d = diff_d;
                op_branch_d = (bus.a != bus.b);
            end
            OP_BLT: begin
                op_result_d = {{(WIDTH-1){1'b0}}, lt_d};
                op_branch_d = lt_d;
            end
            OP_SLT: begin
                op_result_d = {{(WIDTH-1){1'b0}}, lt_d};
                op_branch_d = !lt_d;
            end
            OP_XOR: op_result_d = bus.a ^ bus.b;
            OP_SLL: op_result_d = bus.a;
            default: op_result_d = bus.a + bus.b;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            acc_q       <= '0;
            cnt_q       <= '0;
            result_q    <= '0;
            zero_q      <= 1'b0;
            branch_q    <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (accept_d) begin
                        if (iter_shift_d) begin
                            // Old result (if any) was consumed this edge.
                            acc_q       <= bus.a;
                            cnt_q       <= shamt_d;
                            out_valid_q <= 1'b0;
                            state_q     <= S_SHIFT;
                        end else begin
                            result_q    <= op_result_d;
                            zero_q      <= (op_result_d == '0);
                            branch_q    <= op_branch_d;
                            out_valid_q <= 1'b1;
                            state_q     <= S_DONE;
                        end
                    end else if ((state_q == S_DONE) && bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= S_IDLE;
                    end
                end
                S_SHIFT: begin
                    acc_q <= acc_shl_d;
                    cnt_q <= cnt_q - SHW'(1);
                    // Last step: publish the value being shifted in now.
                    if (cnt_q == SHW'(1)) begin
                        result_q    <= acc_shl_d;
                        zero_q      <= (acc_shl_d == '0);
                        branch_q    <= 1'b0;
                        out_valid_q <= 1'b1;
                        state_q     <= S_DONE;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    state_q     <= S_IDLE;
                end
            endcase
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_alu_exec_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_exec_unit
// Purpose  : Self-checking bench for alu_exec_unit. Expected results are
//            queued on issue and compared when the DUT hands a result over.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_exec_unit;
    logic clock;
    logic reset_n;
    int   checks = 0;
    int   errors = 0;

    logic [33:0] exp_q[$];   // {branch_taken, zero, result}

    alu_exec_unit_if #(.WIDTH(32)) bus ();

    alu_exec_unit #(.WIDTH(32)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [33:0] model(input logic [3:0] op, input logic [31:0] av, input logic [31:0] bv);
        logic [31:0] r;
        logic        br;
        logic        lt;
        lt = $signed(av) < $signed(bv);
        br = 1'b0;
        case (op)
            4'b0000: r = av & bv;
            4'b0001: r = av | bv;
            4'b0110: begin r = av - bv; br = (av == bv); end
            4'b0011: begin r = av - bv; br = (av != bv); end
            4'b1000: begin r = {31'b0, lt}; br = lt; end
            4'b0111: begin r = {31'b0, lt}; br = !lt; end
            4'b1001: r = av ^ bv;
            4'b0100: r = av << bv[4:0];
            default: r = av + bv;
        endcase
        return {br, (r == 32'b0), r};
    endfunction

    // Present an op, wait (bounded) for acceptance, queue its expectation.
    // Returns with inputs deasserted #1 after the accepting edge.
    task automatic issue(input logic [3:0] op, input logic [31:0] av, input logic [31:0] bv,
                         output int waited);
        int n;
        n = 0;
        bus.alu_ctrl = op;
        bus.a        = av;
        bus.b        = bv;
        bus.in_valid = 1'b1;
        @(negedge clock);
        while (!bus.in_ready && n < 100) begin
            n++;
            @(negedge clock);
        end
        waited = n;
        checks++;
        assert (n < 100) else begin
            errors++;
            $error("FAIL issue_timeout: observed=%0d expected=<100", n);
        end
        exp_q.push_back(model(op, av, bv));
        @(posedge clock);
        #1;
        bus.in_valid = 1'b0;
    endtask

    // Scoreboard: compare every result that is handed over.
    always @(negedge clock) begin
        if (reset_n && bus.out_valid && bus.out_ready) begin
            checks++;
            assert (exp_q.size() != 0) else begin
                errors++;
                $error("FAIL unexpected_output: observed=%h expected=none", bus.result);
            end
            if (exp_q.size() != 0) begin
                logic [33:0] e;
                e = exp_q.pop_front();
                chk("sb_result", bus.result, e[31:0]);
                chk("sb_zero", 32'(bus.zero), 32'(e[32]));
                chk("sb_branch", 32'(bus.branch_taken), 32'(e[33]));
            end
        end
    end

    initial begin
        int w;
        int n;
        int stall;

        bus.in_valid  = 1'b0;
        bus.alu_ctrl  = 4'b0;
        bus.a         = 32'b0;
        bus.b         = 32'b0;
        bus.out_ready = 1'b0;
        reset_n       = 1'b0;

        // Reset held for 3 cycles
        repeat (3) @(posedge clock);
        #1;
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_result", bus.result, 32'd0);
        chk("rst_zero", 32'(bus.zero), 32'd0);
        chk("rst_branch", 32'(bus.branch_taken), 32'd0);
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
        reset_n = 1'b1;
        @(posedge clock);
        #1;
        chk("idle_in_ready", 32'(bus.in_ready), 32'd1);
        chk("idle_out_valid", 32'(bus.out_valid), 32'd0);

        // Single-cycle ops, back to back with out_ready high
        bus.out_ready = 1'b1;
        issue(4'b0010, 32'hFFFF_FFFF, 32'd1, w);
        chk("add_latency_valid", 32'(bus.out_valid), 32'd1);
        chk("add_wrap_zero", 32'(bus.zero), 32'd1);
        issue(4'b0110, 32'd5, 32'd7, w);
        chk("beq_result", bus.result, 32'hFFFF_FFFE);
        issue(4'b1000, 32'hFFFF_FFFF, 32'd1, w);
        chk("blt_branch", 32'(bus.branch_taken), 32'd1);
        issue(4'b0111, 32'hFFFF_FFFF, 32'd1, w);
        chk("bge_branch", 32'(bus.branch_taken), 32'd0);
        issue(4'b0011, 32'd9, 32'd9, w);
        chk("bne_branch", 32'(bus.branch_taken), 32'd0);
        issue(4'b1111, 32'h1234_0000, 32'h0000_5678, w);   // unlisted code -> add
        @(posedge clock);
        #1;
        chk("drain_to_idle", 32'(bus.out_valid), 32'd0);

        // Iterative shift by 31 with the consumer stalled
        bus.out_ready = 1'b0;
        issue(4'b0100, 32'h0000_0001, 32'd31, w);
        stall = 0;
        n = 0;
        @(negedge clock);
        while (!bus.out_valid && n < 60) begin
            if (!bus.in_ready) stall++;
            n++;
            @(negedge clock);
        end
        chk("sll31_stall_cycles", 32'(stall), 32'd31);
        chk("sll31_valid", 32'(bus.out_valid), 32'd1);
        for (int i = 0; i < 5; i++) begin
            bus.in_valid = 1'b1;
            bus.alu_ctrl = 4'b0010;
            bus.a        = $urandom;
            bus.b        = $urandom;
            @(posedge clock);
            #1;
            chk("hold_result", bus.result, 32'h8000_0000);
            chk("hold_valid", 32'(bus.out_valid), 32'd1);
            chk("hold_in_ready", 32'(bus.in_ready), 32'd0);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clock);
        #1;
        chk("sll31_consumed", 32'(bus.out_valid), 32'd0);

        // More shifts: wrap-out of bit 31, and a single-step shift to zero
        issue(4'b0100, 32'h8000_0001, 32'd4, w);
        issue(4'b0100, 32'h8000_0000, 32'd1, w);
        n = 0;
        while (!bus.in_ready && n < 20) begin
            n++;
            @(posedge clock);
            #1;
        end

        // Back-to-back throughput: and, or, xor, add
        issue(4'b0000, 32'hF0F0_1234, 32'h0FF0_FFFF, w);
        chk("b2b_valid0", 32'(bus.out_valid), 32'd1);
        issue(4'b0001, 32'hF000_0000, 32'h0000_000F, w);
        chk("b2b_wait1", 32'(w), 32'd0);
        chk("b2b_valid1", 32'(bus.out_valid), 32'd1);
        issue(4'b1001, 32'hAAAA_5555, 32'hFFFF_0000, w);
        chk("b2b_wait2", 32'(w), 32'd0);
        chk("b2b_valid2", 32'(bus.out_valid), 32'd1);
        issue(4'b0010, 32'h7FFF_FFFF, 32'd1, w);
        chk("b2b_wait3", 32'(w), 32'd0);
        chk("b2b_valid3", 32'(bus.out_valid), 32'd1);
        @(posedge clock);
        #1;

        // Reset mid-DONE: out_valid drops asynchronously
        bus.out_ready = 1'b0;
        issue(4'b0010, 32'd3, 32'd4, w);
        chk("done_before_rst", 32'(bus.out_valid), 32'd1);
        @(posedge clock);
        #2;
        reset_n = 1'b0;
        exp_q.delete();
        #1;
        chk("rst_done_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_done_result", bus.result, 32'd0);
        @(posedge clock);
        #1;
        reset_n = 1'b1;

        // Reset mid-SHIFT of a 20-bit shift
        bus.out_ready = 1'b1;
        issue(4'b0100, 32'd3, 32'd20, w);
        repeat (5) @(posedge clock);
        #1;
        chk("in_shift_ready", 32'(bus.in_ready), 32'd0);
        reset_n = 1'b0;
        exp_q.delete();
        #1;
        chk("rst_shift_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_shift_in_ready", 32'(bus.in_ready), 32'd1);
        repeat (2) @(posedge clock);
        #1;
        reset_n = 1'b1;
        @(posedge clock);
        #1;

        // shamt = 0 (upper bits of b ignored) returns a after one cycle
        issue(4'b0100, 32'hDEAD_BEEF, 32'h0000_0100, w);
        chk("sll0_valid", 32'(bus.out_valid), 32'd1);
        chk("sll0_result", bus.result, 32'hDEAD_BEEF);

        n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            n++;
            @(posedge clock);
        end
        #1;
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire
